s_port_rx_checker: RTL and testbench

//  Slave-side receive endpoint that sits directly downstream of a switch output port.

---
 rtl/s_port_rx_checker.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_s_port_rx_checker.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_port_rx_checker.sv
// ---------------------------------------------------------------------------
// s_port_rx_checker
//
// Receive endpoint for one slave port, placed right after a switch output.
// It accepts the packet stream, checks each packet for framing, routing,
// length and CRC-8, reports one status record per packet and keeps
// saturating good/bad packet counters.
//
// Handshake: a beat transfers on a rising clk edge where s_valid and s_ready
// are both 1. s_ready is a register (the inverse of stall from the previous
// cycle, 0 in reset). It never looks at s_valid. Beats that do not transfer
// leave all state untouched.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   s_valid / s_ready  beat handshake
//   s_sop / s_eop      first / last beat of a packet
//   s_data             byte0 = [31:24] ... byte3 = [7:0]
//   s_keep             byte enables, keep[3] = byte0
//   s_dest / s_src     routing IDs, taken from the sop beat
//   s_crc              packet CRC, taken from the eop beat
//   stall              1 drops s_ready on the following cycle
//   pkt_done           one-cycle pulse, status outputs updated
//   pkt_ok             packet had no error
//   pkt_err            {oversize, misroute, framing, crc_bad}
//   pkt_src            source ID of the reported packet
//   pkt_len            byte count of the reported packet, saturates at 4095
//   good_cnt / bad_cnt saturating packet counters
//   dbg_state          FSM state (0 = IDLE, 1 = IN_PKT)
// ---------------------------------------------------------------------------
module s_port_rx_checker #(
  parameter logic [1:0] MY_ID     = 2'd0,
  parameter int         MAX_BYTES = 256,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sop,
  input  logic             s_eop,
  input  logic [31:0]      s_data,
  input  logic [3:0]       s_keep,
  input  logic [1:0]       s_dest,
  input  logic [1:0]       s_src,
  input  logic [7:0]       s_crc,
  input  logic             stall,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [3:0]       pkt_err,
  output logic [1:0]       pkt_src,
  output logic [11:0]      pkt_len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic             dbg_state
);

  localparam logic [12:0] MAX_LEN13 = 13'(MAX_BYTES);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  // One status record, in the same layout as the pkt_* outputs.
  typedef struct packed {
    logic        ok;
    logic [3:0]  err;
    logic [1:0]  src;
    logic [11:0] len;
  } rep_t;

  // CRC-8, polynomial 0x07, one byte MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] data_byte);
    logic [7:0] c;
    c = crc_in ^ data_byte;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  state_t      state, state_n;
  logic        accept;

  // Open-packet accumulators
  logic [7:0]  crc_q;
  logic [11:0] len_q;
  logic        ovr_q;
  logic        frm_q;
  logic [1:0]  dest_q;
  logic [1:0]  src_q;

  // Per-beat datapath
  logic        keep_ok;
  logic [2:0]  beat_bytes;
  logic [7:0]  base_crc;
  logic [11:0] base_len;
  logic        base_ovr;
  logic        base_frm;
  logic [1:0]  dest_eff;
  logic [1:0]  src_eff;
  logic [7:0]  beat_crc;
  logic [12:0] len_sum;
  logic [11:0] new_len;
  logic        new_ovr;
  logic        new_frm;

  // FSM decisions
  logic        acc_load;
  logic        fin_v;
  rep_t        fin_r;
  logic        close_v;
  rep_t        close_r;
  logic [3:0]  fin_err;

  // Report sequencing
  logic        pend_v;
  rep_t        pend_r;
  logic        emit_v;
  rep_t        emit_r;
  logic        store_v;
  rep_t        store_r;

  assign accept    = s_valid & s_ready;
  assign dbg_state = (state == IN_PKT);

  // -------------------------------------------------------------------------
  // Beat datapath. A sop beat starts from fresh accumulators; any other beat
  // continues the open packet.
  // -------------------------------------------------------------------------
  always_comb begin
    keep_ok = 1'b0;
    if (s_eop) begin
      case (s_keep)
        4'b1000, 4'b1100, 4'b1110, 4'b1111: keep_ok = 1'b1;
        default:                            keep_ok = 1'b0;
      endcase
    end else begin
      keep_ok = (s_keep == 4'hF);
    end
  end

  assign beat_bytes = 3'(s_keep[3]) + 3'(s_keep[2]) + 3'(s_keep[1]) + 3'(s_keep[0]);

  always_comb begin
    base_crc = s_sop ? 8'h00  : crc_q;
    base_len = s_sop ? 12'd0  : len_q;
    base_ovr = s_sop ? 1'b0   : ovr_q;
    base_frm = s_sop ? 1'b0   : frm_q;
    dest_eff = s_sop ? s_dest : dest_q;
    src_eff  = s_sop ? s_src  : src_q;

    // Only enabled bytes enter the CRC, in byte0..byte3 order, even when
    // the keep pattern itself is illegal.
    beat_crc = base_crc;
    for (int i = 0; i < 4; i++) begin
      if (s_keep[3-i]) begin
        beat_crc = crc8_byte(beat_crc, s_data[31-8*i -: 8]);
      end
    end

    // One spare bit so a 4095+ length is still seen as oversize and the
    // reported length can clamp instead of wrapping.
    len_sum = {1'b0, base_len} + {10'd0, beat_bytes};
    new_len = len_sum[12] ? 12'hFFF : len_sum[11:0];
    new_ovr = base_ovr | (len_sum > MAX_LEN13);
    new_frm = base_frm | ~keep_ok;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and report generation.
  //   close_*: the open packet is cut short by a new sop (framing error).
  //   fin_*  : a packet ends on this beat, or a stray beat is dropped.
  // Both can fire on the same beat (sop+eop arriving while IN_PKT).
  // -------------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    acc_load = 1'b0;
    fin_v    = 1'b0;
    fin_r    = '0;
    fin_err  = 4'b0000;
    close_v  = 1'b0;
    close_r  = '0;

    if (accept) begin
      if ((state == IN_PKT) && s_sop) begin
        close_v     = 1'b1;
        close_r.ok  = 1'b0;
        close_r.err = {ovr_q, (dest_q != MY_ID), 1'b1, 1'b0};
        close_r.src = src_q;
        close_r.len = len_q;
      end

      if (s_sop || (state == IN_PKT)) begin
        if (s_eop) begin
          fin_err   = {new_ovr, (dest_eff != MY_ID), new_frm, (beat_crc != s_crc)};
          fin_v     = 1'b1;
          fin_r.ok  = (fin_err == 4'b0000);
          fin_r.err = fin_err;
          fin_r.src = src_eff;
          fin_r.len = new_len;
          state_n   = IDLE;
        end else begin
          acc_load = 1'b1;
          state_n  = IN_PKT;
        end
      end else begin
        // Beat with no packet open: dropped, reported as a 0-length bad packet.
        fin_v     = 1'b1;
        fin_r.ok  = 1'b0;
        fin_r.err = 4'b0010;
        fin_r.src = 2'd0;
        fin_r.len = 12'd0;
        state_n   = IDLE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Report sequencing. Only one record can leave per cycle, so when a beat
  // produces two (close + finish) the second waits in pend_r. A held record
  // always goes out before anything new; this cannot overflow because two
  // records per beat need an open packet, and opening one (a sop-only beat)
  // produces no record and so empties the slot first.
  // -------------------------------------------------------------------------
  always_comb begin
    emit_v  = 1'b0;
    emit_r  = '0;
    store_v = 1'b0;
    store_r = '0;
    if (pend_v) begin
      emit_v  = 1'b1;
      emit_r  = pend_r;
      store_v = close_v | fin_v;
      store_r = close_v ? close_r : fin_r;
    end else if (close_v) begin
      emit_v  = 1'b1;
      emit_r  = close_r;
      store_v = fin_v;
      store_r = fin_r;
    end else if (fin_v) begin
      emit_v  = 1'b1;
      emit_r  = fin_r;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ready  <= 1'b0;
      crc_q    <= 8'h00;
      len_q    <= 12'd0;
      ovr_q    <= 1'b0;
      frm_q    <= 1'b0;
      dest_q   <= 2'd0;
      src_q    <= 2'd0;
      pend_v   <= 1'b0;
      pend_r   <= '0;
      pkt_done <= 1'b0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 4'b0000;
      pkt_src  <= 2'd0;
      pkt_len  <= 12'd0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      s_ready <= ~stall;

      if (acc_load) begin
        crc_q  <= beat_crc;
        len_q  <= new_len;
        ovr_q  <= new_ovr;
        frm_q  <= new_frm;
        dest_q <= dest_eff;
        src_q  <= src_eff;
      end

      pend_v <= store_v;
      if (store_v) begin
        pend_r <= store_r;
      end

      pkt_done <= emit_v;
      if (emit_v) begin
        pkt_ok  <= emit_r.ok;
        pkt_err <= emit_r.err;
        pkt_src <= emit_r.src;
        pkt_len <= emit_r.len;
        if (emit_r.ok) begin
          if (good_cnt != {CNT_W{1'b1}}) good_cnt <= good_cnt + CNT_W'(1);
        end else begin
          if (bad_cnt != {CNT_W{1'b1}}) bad_cnt <= bad_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_s_port_rx_checker.sv
// ---------------------------------------------------------------------------
// tb_s_port_rx_checker
//
// Directed bench for s_port_rx_checker (MY_ID=0, MAX_BYTES=256, CNT_W=16).
// Expected status records are pushed into exp_q before each packet is
// driven; a monitor pops one record per pkt_done pulse and compares.
// ---------------------------------------------------------------------------
module tb_s_port_rx_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_sop   = 1'b0;
  logic        s_eop   = 1'b0;
  logic [31:0] s_data  = '0;
  logic [3:0]  s_keep  = '0;
  logic [1:0]  s_dest  = '0;
  logic [1:0]  s_src   = '0;
  logic [7:0]  s_crc   = '0;
  logic        stall;
  logic        pkt_done;
  logic        pkt_ok;
  logic [3:0]  pkt_err;
  logic [1:0]  pkt_src;
  logic [11:0] pkt_len;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
  logic        dbg_state;

  s_port_rx_checker #(
    .MY_ID    (2'd0),
    .MAX_BYTES(256),
    .CNT_W    (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_sop    (s_sop),
    .s_eop    (s_eop),
    .s_data   (s_data),
    .s_keep   (s_keep),
    .s_dest   (s_dest),
    .s_src    (s_src),
    .s_crc    (s_crc),
    .stall    (stall),
    .pkt_done (pkt_done),
    .pkt_ok   (pkt_ok),
    .pkt_err  (pkt_err),
    .pkt_src  (pkt_src),
    .pkt_len  (pkt_len),
    .good_cnt (good_cnt),
    .bad_cnt  (bad_cnt),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int cyc      = 0;
  int exp_good = 0;
  int exp_bad  = 0;
  logic stall_rand = 1'b0;

  logic [18:0] exp_q[$];
  logic [18:0] mon_exp;
  int          done_cyc[$];

  always @(posedge clk) cyc++;

  // Stall is owned by this one process; the main flow only enables it.
  always @(negedge clk) stall = stall_rand ? 1'($urandom_range(0, 1)) : 1'b0;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC-8 reference, poly 0x07, MSB first.
  function automatic logic [7:0] crc8_model(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] r;
    logic       fb;
    r = crc;
    for (int k = 7; k >= 0; k--) begin
      fb = r[7] ^ b[k];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic expect_rep(input logic ok, input logic [3:0] err,
                            input logic [1:0] src, input logic [11:0] len);
    exp_q.push_back({ok, err, src, len});
    if (ok) exp_good++;
    else    exp_bad++;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && pkt_done) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", exp_q.size(), 1);
      end else begin
        mon_exp = exp_q.pop_front();
        check_val("report", {13'd0, pkt_ok, pkt_err, pkt_src, pkt_len}, {13'd0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_sop      = 1'b0;
    s_eop      = 1'b0;
    stall_rand = 1'b0;
    exp_q.delete();
    exp_good   = 0;
    exp_bad    = 0;
    @(negedge clk);
    check_val({tag, "_s_ready"},  s_ready,   0);
    check_val({tag, "_pkt_done"}, pkt_done,  0);
    check_val({tag, "_pkt_ok"},   pkt_ok,    0);
    check_val({tag, "_pkt_err"},  pkt_err,   0);
    check_val({tag, "_pkt_src"},  pkt_src,   0);
    check_val({tag, "_pkt_len"},  pkt_len,   0);
    check_val({tag, "_good"},     good_cnt,  0);
    check_val({tag, "_bad"},      bad_cnt,   0);
    check_val({tag, "_state"},    dbg_state, 0);
    rst_n = 1'b1;
  endtask

  // Presents one beat and returns just after the edge that accepts it.
  task automatic send_beat(input logic sop, input logic eop, input logic [31:0] data,
                           input logic [3:0] keep, input logic [1:0] dest,
                           input logic [1:0] src, input logic [7:0] crc);
    int waited;
    waited = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_sop   = sop;
    s_eop   = eop;
    s_data  = data;
    s_keep  = keep;
    s_dest  = dest;
    s_src   = src;
    s_crc   = crc;
    while (!s_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) check_val("ready_timeout", s_ready, 1);
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    s_valid    = 1'b0;
    s_sop      = 1'b0;
    s_eop      = 1'b0;
    stall_rand = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check_val({tag, "_pending"}, exp_q.size(), 0);
    check_val({tag, "_good"}, good_cnt, exp_good);
    check_val({tag, "_bad"},  bad_cnt,  exp_bad);
  endtask

  // "123456789" in three beats; crc F4 is the correct CRC-8 of it.
  task automatic send_check_str(input logic [1:0] dest, input logic [1:0] src, input logic [7:0] crc);
    send_beat(1'b1, 1'b0, 32'h31323334, 4'hF, dest, src, 8'h00);
    send_beat(1'b0, 1'b0, 32'h35363738, 4'hF, dest, src, 8'h00);
    send_beat(1'b0, 1'b1, 32'h39000000, 4'h8, dest, src, crc);
  endtask

  // All-zero payload: CRC stays 0x00.
  task automatic send_zero_pkt(input int nbeats, input logic [1:0] src);
    for (int i = 0; i < nbeats; i++) begin
      send_beat(i == 0, i == nbeats - 1, 32'h0, 4'hF, 2'd0, src, 8'h00);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [3:0]  keep_tab[4] = '{4'h8, 4'hC, 4'hE, 4'hF};
  int          d0;

  initial begin
    logic [3:0]  k;
    logic [31:0] d;
    logic [1:0]  sr;
    logic [7:0]  c;
    logic [11:0] nb;

    do_reset("rst0");

    // 1: clean 9-byte packet
    expect_rep(1'b1, 4'b0000, 2'd1, 12'd9);
    send_beat(1'b1, 1'b0, 32'h31323334, 4'hF, 2'd0, 2'd1, 8'h00);
    #1 check_val("t1_state_in_pkt", dbg_state, 1);
    send_beat(1'b0, 1'b0, 32'h35363738, 4'hF, 2'd0, 2'd1, 8'h00);
    send_beat(1'b0, 1'b1, 32'h39000000, 4'h8, 2'd0, 2'd1, 8'hF4);
    go_idle();
    drain("t1");

    // 2: wrong CRC
    expect_rep(1'b0, 4'b0001, 2'd1, 12'd9);
    send_check_str(2'd0, 2'd1, 8'hF5);
    go_idle();
    drain("t2");

    // 3: sop inside an open packet, then the new packet completes
    expect_rep(1'b0, 4'b0010, 2'd2, 12'd8);
    expect_rep(1'b1, 4'b0000, 2'd3, 12'd9);
    send_beat(1'b1, 1'b0, 32'h31323334, 4'hF, 2'd0, 2'd2, 8'h00);
    send_beat(1'b0, 1'b0, 32'h35363738, 4'hF, 2'd0, 2'd2, 8'h00);
    send_check_str(2'd0, 2'd3, 8'hF4);
    go_idle();
    drain("t3");

    // 4: misroute, oversize, exact-max length, length saturation
    expect_rep(1'b0, 4'b0100, 2'd2, 12'd9);
    send_check_str(2'd1, 2'd2, 8'hF4);
    expect_rep(1'b0, 4'b1000, 2'd1, 12'd260);
    send_zero_pkt(65, 2'd1);
    expect_rep(1'b1, 4'b0000, 2'd3, 12'd256);
    send_zero_pkt(64, 2'd3);
    expect_rep(1'b0, 4'b1000, 2'd0, 12'd4095);
    send_zero_pkt(1030, 2'd0);
    go_idle();
    drain("t4");

    // Stray beat with no packet open, and illegal keep patterns
    expect_rep(1'b0, 4'b0010, 2'd0, 12'd0);
    send_beat(1'b0, 1'b1, 32'h12345678, 4'hF, 2'd0, 2'd1, 8'h00);
    expect_rep(1'b0, 4'b0010, 2'd1, 12'd2);
    send_beat(1'b1, 1'b1, 32'h0, 4'b0101, 2'd0, 2'd1, 8'h00);
    expect_rep(1'b0, 4'b0010, 2'd2, 12'd7);
    send_beat(1'b1, 1'b0, 32'h0, 4'hE, 2'd0, 2'd2, 8'h00);
    send_beat(1'b0, 1'b1, 32'h0, 4'hF, 2'd0, 2'd2, 8'h00);
    go_idle();
    drain("keep");

    // sop+eop landing on an open packet, followed at full rate by another
    expect_rep(1'b0, 4'b0010, 2'd1, 12'd4);
    expect_rep(1'b1, 4'b0000, 2'd2, 12'd1);
    expect_rep(1'b1, 4'b0000, 2'd3, 12'd2);
    send_beat(1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 2'd1, 8'h00);
    send_beat(1'b1, 1'b1, 32'h0, 4'h8, 2'd0, 2'd2, 8'h00);
    send_beat(1'b1, 1'b1, 32'h0, 4'hC, 2'd0, 2'd3, 8'h00);
    go_idle();
    drain("collide");

    // Full-rate single-beat burst: one pkt_done per cycle, no gaps
    done_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      expect_rep(1'b1, 4'b0000, 2'(i), 12'd4);
      send_beat(1'b1, 1'b1, 32'h0, 4'hF, 2'd0, 2'(i), 8'h00);
    end
    go_idle();
    drain("burst");
    check_val("burst_done_count", done_cyc.size(), 4);
    if (done_cyc.size() == 4) check_val("burst_span", done_cyc[3] - done_cyc[0], 3);

    // 5: 50% random stall, 20 back-to-back single-beat packets
    do_reset("rst5");
    d0 = n_done;
    stall_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      k  = keep_tab[$urandom_range(0, 3)];
      d  = $urandom();
      sr = 2'($urandom_range(0, 3));
      c  = 8'h00;
      nb = 12'd0;
      for (int b = 0; b < 4; b++) begin
        if (k[3-b]) begin
          c  = crc8_model(c, d[31-8*b -: 8]);
          nb = nb + 12'd1;
        end
      end
      expect_rep(1'b1, 4'b0000, sr, nb);
      send_beat(1'b1, 1'b1, d, k, 2'd0, sr, c);
    end
    go_idle();
    drain("t5");
    check_val("t5_done_count", n_done - d0, 20);
    check_val("t5_good_cnt", good_cnt, 20);

    // 6: reset in the middle of a packet, then a clean packet
    send_beat(1'b1, 1'b0, 32'h31323334, 4'hF, 2'd0, 2'd1, 8'h00);
    send_beat(1'b0, 1'b0, 32'h35363738, 4'hF, 2'd0, 2'd1, 8'h00);
    do_reset("rst6");
    expect_rep(1'b1, 4'b0000, 2'd2, 12'd9);
    send_check_str(2'd0, 2'd2, 8'hF4);
    go_idle();
    drain("t6");
    check_val("t6_good_cnt", good_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
